mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store unit between the CPU's MEM pipeline stage and the 512-word × 16-bit data memory. It translates byte-addressed word and byte loads and stores into word-wide memory accesses. Byte stores become a two-cycle read-modify-write. Misaligned, out-of-range and conflicting requests are reported as faults and never reach memory. Every memory-side signal (addrM, write_dataM, write_en, read_dataM) is driven or consumed only by this block.

## Interface
- ADDR_W, 16, byte address width
- WORD_LIMIT, 512, number of valid memory words; valid byte addresses are 0..1023
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- mem_read  in  1  load request, held by the pipeline while stall=1
- mem_write  in  1  store request, held by the pipeline while stall=1
- size  in  1  access size: 0 = 16-bit word, 1 = byte
- sign_ext  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  16  byte address; addr[0] selects the byte (0 = bits 7:0, little-endian)
- wdata  in  16  store data; byte stores use wdata[7:0]
- stall  out  1  pipeline must hold the current request
- rdata  out  16  registered load result
- load_valid  out  1  one-cycle pulse; rdata is valid
- fault  out  1  one-cycle pulse; previous request was rejected
- fault_addr  out  16  addr of the most recent faulting request
- addrM  out  16  word address to memory: {7'b0, addr[9:1]} or the latched address
- write_dataM  out  16  write data to memory
- write_en  out  1  memory write enable; memory captures on the falling edge of clk
- read_dataM  in  16  combinational memory read data

## Operation
- States: IDLE and RMW.
- In IDLE, a request is present when mem_read or mem_write is 1. It is classified as follows:
  - FAULT: both mem_read and mem_write are 1, or addr[15:10] != 0, or size=0 with addr[0]=1.
  - WORD_LD: the unit latches read_dataM into rdata and pulses load_valid the next cycle.
  - WORD_ST: write_en=1 and write_dataM=wdata in the same cycle.
  - BYTE_LD: the unit selects a byte by addr[0], extends it per sign_ext into rdata, and pulses load_valid the next cycle.
  - BYTE_ST: the unit latches read_dataM into merge_reg and latches the word address and addr[0]. stall=1 and write_en=0. Next state is RMW.
- FAULT: no memory write occurs. fault pulses the next cycle and fault_addr<=addr. stall stays 0 so the pipeline proceeds.
- RMW: write_en=1, addrM=latched word address. write_dataM = merge_reg with the selected byte replaced by the latched wdata[7:0]. Next state is IDLE unconditionally. In this cycle stall=1 if any request is present, and that request is not accepted until IDLE.
- The unit supports one outstanding operation only. Requests never overlap.
- addrM follows {7'b0, addr[9:1]} in IDLE even when no request is present. write_en=0 in IDLE unless the request is a valid WORD_ST.

## Timing
- Reset (asynchronous, while reset=0):
  - State goes to IDLE.
  - rdata=0, load_valid=0, fault=0, fault_addr=0, merge_reg=0.
  - write_en is forced to 0 combinationally.
- Reset asserted during RMW abandons the write. No partial write occurs after the write_en-low reset assertion.
- Load latency is 1 cycle: request in cycle N gives load_valid=1 with rdata in cycle N+1.
- Word store completes in 1 cycle, written on the falling edge within cycle N.
- Byte store takes 2 cycles: read in cycle N, write on the falling edge of cycle N+1. A back-to-back byte store is accepted at N+2.
- load_valid and fault are never both 1. Both are 0 in any cycle following a store or an idle cycle.
- stall = (IDLE and valid BYTE_ST) or (RMW and (mem_read or mem_write)).
- A load immediately after a byte store to the same word returns the merged value. The write precedes the load because the load is sampled in IDLE after RMW.

## Test plan
- Data memory holds word i = i after reset. Word load at addr=0x0014 → load_valid next cycle, rdata=0x000A.
- Byte load at addr=0x0015 with word 0x000A = 0x80F3 preloaded, sign_ext=1 → rdata=0xFF80. Same access with sign_ext=0 → rdata=0x0080.
- Byte store wdata=0x00AB at addr=0x0020 (word 0x10 = 0x0010) → stall=1 for 1 cycle, write_en=1 in the next cycle with write_dataM=0x00AB. A subsequent word load returns 0x00AB. A byte store to 0x0021 then yields 0xABAB.
- Word store at odd addr=0x0003, addr=0x0800, and mem_read=mem_write=1 → write_en stays 0, fault pulses one cycle later each time, and fault_addr=0x0003, 0x0800, then the third address.
- Back-to-back byte store followed by word load → second request held (stall=1 in RMW), load accepted in the next IDLE, correct merged data returned.
- reset pulled low during the RMW cycle → write_en drops immediately, all outputs zero, state IDLE, memory word unchanged apart from memory's own reset.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and the 512x16 data memory.
// Word accesses complete in one cycle; byte stores are a two-cycle read-modify-write.
module mem_access_unit #(
  parameter int ADDR_W     = 16,
  parameter int WORD_LIMIT = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic              stall,
  output logic [15:0]       rdata,
  output logic              load_valid,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [ADDR_W-1:0] addrM,
  output logic [15:0]       write_dataM,
  output logic              write_en,
  input  logic [15:0]       read_dataM
);

  localparam int          WIDX       = $clog2(WORD_LIMIT);
  localparam int unsigned BYTE_LIMIT = 2 * WORD_LIMIT;

  typedef enum logic {IDLE, RMW} state_t;

  state_t              r_state, w_next;
  logic [15:0]         r_rdata, r_merge;
  logic                r_lv, r_fault, r_bsel;
  logic [ADDR_W-1:0]   r_fa, r_waddr;
  logic [7:0]          r_wbyte;

  logic                w_req, w_oor, w_fault, w_ok;
  logic                w_word_ld, w_word_st, w_byte_ld, w_byte_st;
  logic [ADDR_W-1:0]   w_waddr;
  logic [7:0]          w_byte;
  logic [15:0]         w_byte_ext, w_merged;

  // Classification only matters in IDLE; RMW ignores whatever is presented.
  assign w_req     = mem_read | mem_write;
  assign w_oor     = (32'(addr) >= BYTE_LIMIT);
  assign w_fault   = w_req & ((mem_read & mem_write) | w_oor | (~size & addr[0]));
  assign w_ok      = w_req & ~w_fault;
  assign w_word_ld = w_ok & mem_read  & ~size;
  assign w_word_st = w_ok & mem_write & ~size;
  assign w_byte_ld = w_ok & mem_read  &  size;
  assign w_byte_st = w_ok & mem_write &  size;

  assign w_waddr    = ADDR_W'(addr[WIDX:1]);
  assign w_byte     = addr[0] ? read_dataM[15:8] : read_dataM[7:0];
  assign w_byte_ext = sign_ext ? {{8{w_byte[7]}}, w_byte} : {8'h00, w_byte};
  assign w_merged   = r_bsel ? {r_wbyte, r_merge[7:0]} : {r_merge[15:8], r_wbyte};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rdata <= '0;
      r_lv    <= 1'b0;
      r_fault <= 1'b0;
      r_fa    <= '0;
      r_merge <= '0;
      r_waddr <= '0;
      r_bsel  <= 1'b0;
      r_wbyte <= '0;
    end else begin
      r_state <= w_next;
      r_lv    <= (r_state == IDLE) & (w_word_ld | w_byte_ld);
      r_fault <= (r_state == IDLE) & w_fault;
      if (r_state == IDLE) begin
        if (w_word_ld) r_rdata <= read_dataM;
        if (w_byte_ld) r_rdata <= w_byte_ext;
        if (w_fault)   r_fa    <= addr;
        if (w_byte_st) begin
          r_merge <= read_dataM;
          r_waddr <= w_waddr;
          r_bsel  <= addr[0];
          r_wbyte <= wdata[7:0];
        end
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    stall       = 1'b0;
    write_en    = 1'b0;
    addrM       = w_waddr;
    write_dataM = wdata;
    case (r_state)
      IDLE: begin
        write_en = w_word_st;
        if (w_byte_st) begin
          stall  = 1'b1;
          w_next = RMW;
        end
      end
      RMW: begin
        addrM       = r_waddr;
        write_dataM = w_merged;
        write_en    = 1'b1;
        stall       = w_req;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Memory writes on the falling edge, so reset must kill the enable at once.
    if (!reset) write_en = 1'b0;
  end

  assign rdata      = r_rdata;
  assign load_valid = r_lv;
  assign fault      = r_fault;
  assign fault_addr = r_fa;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan steps plus random traffic against
// an array model of the data memory.
module tb_mem_access_unit;

  logic        clk = 1'b0, reset;
  logic        mem_read, mem_write, size, sign_ext;
  logic [15:0] addr, wdata;
  logic        stall, load_valid, fault, write_en;
  logic [15:0] rdata, fault_addr, addrM, write_dataM, read_dataM;

  logic [15:0] mem     [512];
  logic [15:0] exp_mem [512];
  logic [15:0] exp_rd, exp_fa;
  int          n_err = 0, n_chk = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .load_valid(load_valid), .fault(fault),
    .fault_addr(fault_addr), .addrM(addrM), .write_dataM(write_dataM),
    .write_en(write_en), .read_dataM(read_dataM)
  );

  always #5 clk = ~clk;

  assign read_dataM = mem[addrM[8:0]];
  always @(negedge clk) if (write_en) mem[addrM[8:0]] <= write_dataM;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle();
    mem_read = 0; mem_write = 0;
    #1;
    chk("idle_we", 16'(write_en), 16'd0);
    chk("idle_stall", 16'(stall), 16'd0);
    @(posedge clk); #1;
    chk("idle_lv", 16'(load_valid), 16'd0);
    chk("idle_fault", 16'(fault), 16'd0);
  endtask

  // Called at posedge+1 with the unit idle; returns at posedge+1.
  task automatic op(input logic rd, input logic wr, input logic sz, input logic sx,
                    input logic [15:0] a, input logic [15:0] d);
    logic f;
    logic [8:0] w;
    logic [15:0] cur, nw;
    logic [7:0] b;
    f   = (rd && wr) || (a[15:10] != 0) || (!sz && a[0]);
    w   = a[9:1];
    cur = exp_mem[w];
    mem_read = rd; mem_write = wr; size = sz; sign_ext = sx; addr = a; wdata = d;
    #1;
    chk("req_stall", 16'(stall), 16'(!f && wr && sz));
    chk("req_we", 16'(write_en), 16'(!f && wr && !sz));
    chk("req_addrM", addrM, {7'b0, w});
    if (!f && wr && !sz) begin
      chk("wst_data", write_dataM, d);
      exp_mem[w] = d;
    end
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
    if (!f && wr && sz) begin
      nw = a[0] ? {d[7:0], cur[7:0]} : {cur[15:8], d[7:0]};
      chk("rmw_lv", 16'(load_valid), 16'd0);
      chk("rmw_fault", 16'(fault), 16'd0);
      #1;
      chk("rmw_we", 16'(write_en), 16'd1);
      chk("rmw_addrM", addrM, {7'b0, w});
      chk("rmw_data", write_dataM, nw);
      chk("rmw_stall", 16'(stall), 16'd0);
      exp_mem[w] = nw;
      @(posedge clk); #1;
    end
    if (f) exp_fa = a;
    else if (rd) begin
      b = a[0] ? cur[15:8] : cur[7:0];
      exp_rd = sz ? (sx ? {{8{b[7]}}, b} : {8'h00, b}) : cur;
    end
    chk("lv", 16'(load_valid), 16'(!f && rd));
    chk("fault", 16'(fault), 16'(f));
    chk("rdata", rdata, exp_rd);
    chk("fault_addr", fault_addr, exp_fa);
  endtask

  initial begin
    logic [15:0] a, nw;
    int sel;
    for (int i = 0; i < 512; i++) begin
      mem[i] = 16'(i);
      exp_mem[i] = 16'(i);
    end
    exp_rd = 0; exp_fa = 0;
    reset = 0; mem_read = 0; mem_write = 0; size = 0; sign_ext = 0; addr = 0; wdata = 0;
    #12;
    chk("rst_rdata", rdata, 16'd0);
    chk("rst_lv", 16'(load_valid), 16'd0);
    chk("rst_fault", 16'(fault), 16'd0);
    chk("rst_fa", fault_addr, 16'd0);
    chk("rst_we", 16'(write_en), 16'd0);
    chk("rst_stall", 16'(stall), 16'd0);
    reset = 1;
    @(posedge clk); #1;

    op(1, 0, 0, 0, 16'h0014, 16'h0);
    chk("plan_wld", rdata, 16'h000A);
    op(0, 1, 0, 0, 16'h0014, 16'h80F3);
    op(1, 0, 1, 1, 16'h0015, 16'h0);
    chk("plan_bld_sx", rdata, 16'hFF80);
    op(1, 0, 1, 0, 16'h0015, 16'h0);
    chk("plan_bld_zx", rdata, 16'h0080);
    op(0, 1, 1, 0, 16'h0020, 16'h00AB);
    op(1, 0, 0, 0, 16'h0020, 16'h0);
    chk("plan_bst_lo", rdata, 16'h00AB);
    op(0, 1, 1, 0, 16'h0021, 16'h00AB);
    op(1, 0, 0, 0, 16'h0020, 16'h0);
    chk("plan_bst_hi", rdata, 16'hABAB);

    op(0, 1, 0, 0, 16'h0003, 16'h1111);
    chk("plan_fa1", fault_addr, 16'h0003);
    idle_cycle();
    op(0, 1, 0, 0, 16'h0800, 16'h2222);
    chk("plan_fa2", fault_addr, 16'h0800);
    idle_cycle();
    op(1, 1, 0, 0, 16'h0030, 16'h3333);
    chk("plan_fa3", fault_addr, 16'h0030);
    idle_cycle();
    op(1, 0, 0, 0, 16'h0002, 16'h0);
    chk("fault_nowrite", rdata, 16'h0001);

    // Byte store with a word load presented during RMW.
    nw = {exp_mem[9'h11][15:8], 8'h5C};
    mem_write = 1; mem_read = 0; size = 1; addr = 16'h0022; wdata = 16'h005C;
    #1; chk("bb_stall0", 16'(stall), 16'd1);
    @(posedge clk); #1;
    mem_write = 0; mem_read = 1; size = 0; addr = 16'h0022;
    #1;
    chk("bb_stall1", 16'(stall), 16'd1);
    chk("bb_we", 16'(write_en), 16'd1);
    chk("bb_data", write_dataM, nw);
    chk("bb_lv_rmw", 16'(load_valid), 16'd0);
    exp_mem[9'h11] = nw;
    @(posedge clk); #1;
    chk("bb_lv_idle", 16'(load_valid), 16'd0);
    #1;
    chk("bb_stall2", 16'(stall), 16'd0);
    chk("bb_we2", 16'(write_en), 16'd0);
    @(posedge clk); #1;
    mem_read = 0;
    chk("bb_lv", 16'(load_valid), 16'd1);
    chk("bb_rdata", rdata, nw);
    exp_rd = nw;

    // Reset asserted in the RMW cycle abandons the write.
    mem_write = 1; size = 1; addr = 16'h0040; wdata = 16'h0077;
    #1; chk("rr_stall", 16'(stall), 16'd1);
    @(posedge clk); #1;
    mem_write = 0;
    reset = 0;
    #1;
    chk("rr_we", 16'(write_en), 16'd0);
    chk("rr_rdata", rdata, 16'd0);
    chk("rr_fa", fault_addr, 16'd0);
    chk("rr_lv", 16'(load_valid), 16'd0);
    chk("rr_fault", 16'(fault), 16'd0);
    chk("rr_stall2", 16'(stall), 16'd0);
    exp_rd = 0; exp_fa = 0;
    @(negedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    op(1, 0, 0, 0, 16'h0040, 16'h0);
    chk("rr_mem", rdata, 16'h0020);

    for (int k = 0; k < 200; k++) begin
      sel = int'($urandom_range(0, 19));
      a   = 16'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = a | (16'h0400 << $urandom_range(0, 5));
      if (sel == 19) idle_cycle();
      else op(sel < 9 || sel == 18, sel >= 9, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), a, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
